// File: rtl/desacople_if.sv
// Pin-side bundle for the decoupling controller: enable, raw A0/A1 pairs and transistor drive lines.
// Carries no handshake; the inputs are level signals and the outputs are registered levels.
interface desacople_if #(
   parameter int NUM_CH = 4
) ();
   logic              en;
   logic [NUM_CH-1:0] a0;
   logic [NUM_CH-1:0] a1;
   logic [NUM_CH-1:0] desacople_out;
   logic              any_active;

   modport master (
      output en, a0, a1,
      input  desacople_out, any_active
   );

   modport slave (
      input  en, a0, a1,
      output desacople_out, any_active
   );
endinterface

// File: rtl/desacople_ctrl.sv
// Per-channel sync -> XOR -> debounce -> minimum-on FSM driving one transistor line each.
// Input-to-output latency SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges; no backpressure, en low kills outputs in 1 edge.
module desacople_ctrl #(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_ON_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   desacople_if.slave bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = (MIN_ON_CYCLES > 1) ? $clog2(MIN_ON_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_HOLD = 2'd1,
      ST_ON   = 2'd2
   } state_t;

   logic [NUM_CH-1:0] a0_sync [SYNC_STAGES];
   logic [NUM_CH-1:0] a1_sync [SYNC_STAGES];
   logic [NUM_CH-1:0] cond;
   logic [NUM_CH-1:0] out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            a0_sync[s] <= '0;
            a1_sync[s] <= '0;
         end
      end else begin
         a0_sync[0] <= bus.a0;
         a1_sync[0] <= bus.a1;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            a0_sync[s] <= a0_sync[s-1];
            a1_sync[s] <= a1_sync[s-1];
         end
      end
   end

   assign cond = a0_sync[SYNC_STAGES-1] ^ a1_sync[SYNC_STAGES-1];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic          deb;
      logic [DW-1:0] dcnt;
      state_t        state;
      state_t        state_nxt;
      logic [HW-1:0] hcnt;
      logic [HW-1:0] hcnt_nxt;
      logic          out_r;

      // Any single cycle of agreement restarts the persistence count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            deb  <= 1'b0;
            dcnt <= '0;
         end else if (cond[i] == deb) begin
            dcnt <= '0;
         end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb  <= cond[i];
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end

      always_comb begin
         state_nxt = state;
         hcnt_nxt  = hcnt;
         case (state)
            ST_OFF: begin
               if (bus.en && deb) begin
                  state_nxt = ST_HOLD;
                  hcnt_nxt  = HW'(MIN_ON_CYCLES - 1);
               end
            end
            ST_HOLD: begin
               // deb is deliberately ignored until the hold count expires.
               if (!bus.en)         state_nxt = ST_OFF;
               else if (hcnt != '0) hcnt_nxt  = hcnt - 1'b1;
               else if (deb)        state_nxt = ST_ON;
               else                 state_nxt = ST_OFF;
            end
            ST_ON: begin
               if (!bus.en || !deb) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= ST_OFF;
            hcnt  <= '0;
            out_r <= 1'b0;
         end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            out_r <= (state_nxt != ST_OFF);
         end
      end

      assign out_q[i] = out_r;
   end

   assign bus.desacople_out = out_q;
   assign bus.any_active    = |out_q;

endmodule
